uart_rx: RTL

- 8N1 UART receiver that sits directly upstream of the 16-bit word assembler.
- Samples the asynchronous rx pin, recovers one byte per frame, and presents it on uart_byte with a level-held uart_byte_ready strobe.
- The strobe is held long enough for the downstream stage's 3-cycle-high-after-low detector to catch it.
- Also flags framing errors for debug/status.

---
 rtl/uart_rx_pkg.sv | 16 +
 rtl/uart_rx_sync_2ff.sv | 27 ++
 rtl/uart_rx.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/uart_rx_pkg.sv
// Shared definitions for the serial receive path and the word assembler
// that consumes its bytes.
package uart_rx_pkg;

   localparam int UART_CLKS_PER_BIT = 434;
   localparam int WORD_WIDTH        = 16;

   typedef enum logic [2:0] {
      RX_IDLE      = 3'd0,
      RX_START     = 3'd1,
      RX_DATA      = 3'd2,
      RX_STOP      = 3'd3,
      RX_WAIT_IDLE = 3'd4
   } rx_state_t;

endpackage

// File: rtl/uart_rx_sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input; the reset value
// should match the input's idle level so no false edge appears after reset.
module sync_2ff #(
   parameter logic RST_VAL = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic i_d,
   output logic o_q
);

   logic r_meta;
   logic r_q;

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_meta <= RST_VAL;
         r_q    <= RST_VAL;
      end else begin
         r_meta <= i_d;
         r_q    <= r_meta;
      end
   end

   assign o_q = r_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1 receiver: mid-bit sampling of the synchronized line, byte delivery
// with a level-held ready strobe, and a one-cycle framing error pulse.
module uart_rx
   import uart_rx_pkg::*;
#(
   parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
   parameter int READY_CYCLES = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx,
   output logic [7:0] uart_byte,
   output logic       uart_byte_ready,
   output logic       framing_err,
   output logic       rx_busy
);

   localparam int              CW        = $clog2(CLKS_PER_BIT) + 1;
   localparam int              RW        = $clog2(READY_CYCLES);
   localparam logic [CW-1:0]   HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CW-1:0]   BIT_LAST  = CW'(CLKS_PER_BIT - 1);
   localparam logic [RW-1:0]   RDY_LAST  = RW'(READY_CYCLES - 1);

   rx_state_t     r_state;
   logic [CW-1:0] r_clk_cnt;
   logic [2:0]    r_bit_cnt;
   logic [7:0]    r_shift;
   logic [7:0]    r_byte;
   logic          r_ferr;
   logic          r_busy;
   logic [RW-1:0] r_rdy_cnt;
   logic          r_rdy;

   logic w_rxs;
   logic w_bit_end;
   logic w_stop_ok;

   sync_2ff #(.RST_VAL(1'b1)) u_rx_sync (
      .clk (clk),
      .rst (rst),
      .i_d (rx),
      .o_q (w_rxs)
   );

   assign w_bit_end = (r_clk_cnt == BIT_LAST);
   assign w_stop_ok = (r_state == RX_STOP) && w_bit_end && w_rxs;

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state   <= RX_IDLE;
         r_clk_cnt <= '0;
         r_bit_cnt <= '0;
         r_shift   <= '0;
         r_byte    <= '0;
         r_ferr    <= 1'b0;
         r_busy    <= 1'b0;
      end else begin
         r_ferr <= 1'b0;
         case (r_state)
            RX_IDLE: begin
               if (!w_rxs) begin
                  r_state   <= RX_START;
                  r_clk_cnt <= '0;
                  r_busy    <= 1'b1;
               end
            end
            // A start bit that is high again at its midpoint is a glitch.
            RX_START: begin
               if (r_clk_cnt == HALF_LAST) begin
                  r_clk_cnt <= '0;
                  r_bit_cnt <= '0;
                  if (!w_rxs) begin
                     r_state <= RX_DATA;
                  end else begin
                     r_state <= RX_IDLE;
                     r_busy  <= 1'b0;
                  end
               end else begin
                  r_clk_cnt <= r_clk_cnt + 1'b1;
               end
            end
            RX_DATA: begin
               if (w_bit_end) begin
                  r_clk_cnt <= '0;
                  r_shift   <= {w_rxs, r_shift[7:1]};
                  r_bit_cnt <= r_bit_cnt + 1'b1;
                  if (r_bit_cnt == 3'd7) r_state <= RX_STOP;
               end else begin
                  r_clk_cnt <= r_clk_cnt + 1'b1;
               end
            end
            // Leaving at mid-stop-bit keeps a back-to-back start edge visible.
            RX_STOP: begin
               if (w_bit_end) begin
                  r_clk_cnt <= '0;
                  if (w_rxs) begin
                     r_byte  <= r_shift;
                     r_state <= RX_IDLE;
                     r_busy  <= 1'b0;
                  end else begin
                     r_ferr  <= 1'b1;
                     r_state <= RX_WAIT_IDLE;
                  end
               end else begin
                  r_clk_cnt <= r_clk_cnt + 1'b1;
               end
            end
            RX_WAIT_IDLE: begin
               if (w_rxs) begin
                  r_state <= RX_IDLE;
                  r_busy  <= 1'b0;
               end
            end
            default: begin
               r_state <= RX_IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   // Ready hold runs independently so the next frame can start underneath it.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_rdy     <= 1'b0;
         r_rdy_cnt <= '0;
      end else if (w_stop_ok) begin
         r_rdy     <= 1'b1;
         r_rdy_cnt <= RDY_LAST;
      end else if (r_rdy) begin
         if (r_rdy_cnt == '0) r_rdy <= 1'b0;
         else                 r_rdy_cnt <= r_rdy_cnt - 1'b1;
      end
   end

   assign uart_byte       = r_byte;
   assign uart_byte_ready = r_rdy;
   assign framing_err     = r_ferr;
   assign rx_busy         = r_busy;

endmodule
